// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared widths and the stereo sample-pair type for the I2S
//            transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int I2S_DATA_W    = 24;
    localparam int I2S_SLOT_BITS = 32;

    // One stereo frame's worth of samples, left in the upper half.
    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } i2s_pair_t;

endpackage
`default_nettype wire

// File: rtl/i2s_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_shifter
// Purpose  : Per-slot bit counter and MSB-first serialiser. A slot start
//            drives the one-bit-delay zero and loads the channel word; each
//            later SCK fall emits the next data bit or padding.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_shifter
    import i2s_pkg::*;
#(
    parameter int DATA_W    = I2S_DATA_W,
    parameter int SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      fall,
    input  logic      ws_chg,
    input  logic      ws,
    input  i2s_pair_t pair,
    output logic      sd
);

    localparam int              CNT_W     = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_W);

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;

    // Slot restart on WS change, otherwise step one bit per SCK fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            sd      <= 1'b0;
        end else if (ws_chg) begin
            // This fall is the last bit time of the previous channel.
            bit_cnt <= '0;
            sd      <= 1'b0;
            shift   <= ws ? pair.right : pair.left;
        end else if (fall) begin
            if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            sd    <= (bit_cnt < DATA_BITS) ? shift[DATA_W-1] : 1'b0;
            shift <= {shift[DATA_W-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_transmit_24.sv
`default_nettype none
// ============================================================================
// Module   : i2s_transmit_24
// Purpose  : Serialises 24-bit stereo pairs onto an I2S data line using the
//            externally generated SCK/WS. A one-pair holding buffer decouples
//            the valid/ready producer from frame timing.
// Options  : I2S_TX_REPEAT_EN - repeat the last pair on underrun instead of
//            sending silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_transmit_24
    import i2s_pkg::*;
#(
    // DATA_W must match I2S_DATA_W: the pair type is sized by the package.
    parameter int DATA_W    = I2S_DATA_W,
    parameter int SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sd_o,
    output logic              frame_start_o,
    output logic              underrun_o
);

    logic      sck_q;
    logic      ws_lat;
    logic      fall;
    logic      ws_chg;
    logic      frame_start;
    logic      accept;
    logic      hold_full;
    i2s_pair_t hold_pair;
    i2s_pair_t tx_pair;
    i2s_pair_t tx_next;

    assign fall        = sck_q & ~sck_i;
    assign ws_chg      = fall & (ws_i != ws_lat);
    assign frame_start = ws_chg & ~ws_i;
    assign ready_o     = ~hold_full;
    assign accept      = valid_i & ~hold_full;

    // SCK history and WS value seen at the last SCK fall. ws_lat resets
    // high so the first left slot after reset counts as a frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q  <= 1'b0;
            ws_lat <= 1'b1;
        end else begin
            sck_q <= sck_i;
            if (fall) begin
                ws_lat <= ws_i;
            end
        end
    end

    // Holding buffer: a same-cycle acceptance at an empty frame start stays
    // held for the next frame, because frame start only drains a full buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_full <= 1'b0;
            hold_pair <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_pair <= '{left: left_i, right: right_i};
        end else if (frame_start) begin
            hold_full <= 1'b0;
        end
    end

    // Pair for the frame being started; the shifter selects from this so the
    // left word is available in the very cycle it is loaded.
    always_comb begin
        tx_next = tx_pair;
        if (frame_start) begin
            if (hold_full) begin
                tx_next = hold_pair;
            end else begin
`ifdef I2S_TX_REPEAT_EN
                tx_next = tx_pair;
`else
                tx_next = '0;
`endif
            end
        end
    end

    // Transmit pair register and frame/underrun status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_pair       <= '0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            tx_pair       <= tx_next;
            frame_start_o <= frame_start;
            underrun_o    <= frame_start & ~hold_full;
        end
    end

    i2s_tx_shifter #(
        .DATA_W    (DATA_W),
        .SLOT_BITS (SLOT_BITS)
    ) u_shifter (
        .clk    (clk_i),
        .rst    (rst_i),
        .fall   (fall),
        .ws_chg (ws_chg),
        .ws     (ws_i),
        .pair   (tx_next),
        .sd     (sd_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmit_24.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_transmit_24
// Purpose  : Directed bench for i2s_transmit_24. Generates SCK/WS like
//            i2s_clock_gen (SCK = clk/4, 32 SCK per slot), decodes the line
//            like an I2S receiver and compares whole frames against a
//            scoreboard of expected pairs.
// Options  : I2S_TX_REPEAT_EN - expected underrun frames repeat the last pair.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_transmit_24;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        sck_i;
    logic        ws_i;
    logic [23:0] left_i;
    logic [23:0] right_i;
    logic        valid_i;
    logic        ready_o;
    logic        sd_o;
    logic        frame_start_o;
    logic        underrun_o;

    i2s_transmit_24 dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .sck_i         (sck_i),
        .ws_i          (ws_i),
        .left_i        (left_i),
        .right_i       (right_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .sd_o          (sd_o),
        .frame_start_o (frame_start_o),
        .underrun_o    (underrun_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          ph, fc, rcnt;
    bit          started;
    logic [31:0] slot_bits, lraw;
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    int          fs_cnt = 0;
    int          acc_cnt = 0;
    logic        last_ur = 1'b0;
    int          fnum = 0;

    // Expected 64 rising-edge samples of one frame: delay bit, word, padding.
    function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // SCK/WS generator plus receiver: samples sd_o on every rising SCK.
    initial begin
        logic nws;
        sck_i = 1'b1; ws_i = 1'b0; ph = 0; fc = 0; rcnt = 40;
        started = 1'b0; slot_bits = '0; lraw = '0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            if (ph == 0) begin
                sck_i = 1'b1;
                slot_bits = {slot_bits[30:0], sd_o};
                if (rcnt == 31) begin
                    if (!ws_i) lraw = slot_bits;
                    else if (started) got.push_back({lraw, slot_bits});
                end
                rcnt++;
            end else if (ph == 2) begin
                sck_i = 1'b0;
                fc = (fc + 1) % 64;
                nws = (fc >= 32);
                if (nws != ws_i) begin
                    rcnt = 0;
                    if (!nws) started = 1'b1;
                    ws_i = nws;
                end
            end
        end
    end

    // Frame-start pulses and the underrun flag that came with the latest one.
    always @(negedge clk) begin
        if (frame_start_o) begin
            fs_cnt++;
            last_ur = underrun_o;
        end
    end

    // Handshake acceptances, sampled as the DUT samples them.
    always @(posedge clk) begin
        if (!rst_i && valid_i && ready_o) acc_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out, observed none expected event", tag);
    endtask

    task automatic wait_fs();
        int old = fs_cnt;
        int n = 0;
        while (fs_cnt == old && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (fs_cnt == old) timeout("wait_fs");
    endtask

    // Present a pair and return on the negedge after it is accepted.
    // valid_i is left high; the caller follows with send() or idle().
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        left_i = l; right_i = r; valid_i = 1'b1;
        while (!ready_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) timeout("send");
        @(negedge clk);
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    task automatic drain();
        logic [63:0] e, g;
        int n = 0;
        while (got.size() < exp_q.size() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (got.size() < exp_q.size()) begin
            timeout("drain");
            got.delete();
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = got.pop_front();
                check($sformatf("frame%0d", fnum), g, e);
                fnum++;
            end
        end
    endtask

    initial begin
        logic [23:0] pl[4];
        logic [23:0] pr[4];
        logic [63:0] ex_u;
        logic        sd_seen;
        int          acc0, fs0, n;

        rst_i = 1'b1; valid_i = 1'b0; left_i = '0; right_i = '0;
        for (int i = 0; i < 4; i++) begin
            pl[i] = 24'($urandom);
            pr[i] = 24'($urandom);
        end
`ifdef I2S_TX_REPEAT_EN
        ex_u = fr(pl[3], pr[3]);
`else
        ex_u = fr(24'h0, 24'h0);
`endif
        repeat (4) @(negedge clk);
        check("reset_sd", 64'(sd_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_frame_start", 64'(frame_start_o), 64'd0);
        check("reset_underrun", 64'(underrun_o), 64'd0);
        rst_i = 1'b0;

        // Basic frame
        wait_fs();
        send(24'hA5F00F, 24'h123456);
        idle();
        check("held_ready_low", 64'(ready_o), 64'd0);
        wait_fs();
        got.delete();
        exp_q.push_back(fr(24'hA5F00F, 24'h123456));
        check("basic_no_underrun", 64'(last_ur), 64'd0);
        check("ready_after_xfer", 64'(ready_o), 64'd1);

        // Streaming with valid held high (back-pressure)
        acc0 = acc_cnt;
        fs0  = fs_cnt;
        for (int i = 0; i < 4; i++) begin
            send(pl[i], pr[i]);
            exp_q.push_back(fr(pl[i], pr[i]));
            if (i == 0) begin
                repeat (20) @(negedge clk);
                check("backpressure_ready", 64'(ready_o), 64'd0);
            end
        end
        check("accepts_in_stream", 64'(acc_cnt - acc0), 64'd4);
        check("frames_in_stream", 64'(fs_cnt - fs0), 64'd3);
        idle();

        // Underrun
        wait_fs();
        check("last_pair_no_underrun", 64'(last_ur), 64'd0);
        wait_fs();
        check("underrun_flag", 64'(last_ur), 64'd1);
        exp_q.push_back(ex_u);

        // Accept in the frame-start cycle with an empty buffer
        fs0 = fs_cnt;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(fc == 63 && ph == 1) && n < 600);
        if (n >= 600) timeout("align_frame_start");
        @(negedge clk);
        left_i = 24'h7FFFFF; right_i = 24'h800001; valid_i = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        check("simul_frame_start", 64'(fs_cnt - fs0), 64'd1);
        check("simul_underrun", 64'(last_ur), 64'd1);
        check("simul_pair_held", 64'(ready_o), 64'd0);
        exp_q.push_back(ex_u);
        exp_q.push_back(fr(24'h7FFFFF, 24'h800001));
        drain();

        // Reset mid-frame at about bit 10 of the left slot
        wait_fs();
        send(24'h111111, 24'h222222);
        idle();
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(fc == 11 && ph == 3) && n < 600);
        if (n >= 600) timeout("align_bit10");
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("midreset_sd", 64'(sd_o), 64'd0);
        check("midreset_ready", 64'(ready_o), 64'd1);
        check("midreset_frame_start", 64'(frame_start_o), 64'd0);
        check("midreset_underrun", 64'(underrun_o), 64'd0);
        sd_seen = 1'b0;
        n = 0;
        while (!ws_i && n < 600) begin
            @(negedge clk);
            sd_seen = sd_seen | sd_o;
            n++;
        end
        check("midreset_line_quiet", 64'(sd_seen), 64'd0);
        send(24'hC0FFEE, 24'h0BEEF5);
        idle();
        wait_fs();
        got.delete();
        check("resume_no_underrun", 64'(last_ur), 64'd0);
        exp_q.push_back(fr(24'hC0FFEE, 24'h0BEEF5));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
